// File: rtl/astropix_frame_deframer_if.sv
// astropix_frame_deframer_if: framed byte stream in, parallel frame record out
//   s_axis_*  : byte stream (tdata/tvalid/tlast from upstream, tready back)
//   m_rec_*   : one record per good frame (valid/fields out, ready back)
//   slave     : deframer view, master : environment view
interface astropix_frame_deframer_if #(parameter int MAX_PAYLOAD = 7);
  logic [7:0] s_axis_tdata;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic m_rec_valid, m_rec_ready;
  logic [7:0] m_rec_layer, m_rec_header;
  logic [2:0] m_rec_count;
  logic [8*MAX_PAYLOAD-1:0] m_rec_payload;
  logic [31:0] m_rec_timestamp;
  modport slave (
    input s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_rec_ready,
    output s_axis_tready, m_rec_valid, m_rec_layer, m_rec_header, m_rec_count,
    m_rec_payload, m_rec_timestamp
  );
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_rec_ready,
    input s_axis_tready, m_rec_valid, m_rec_layer, m_rec_header, m_rec_count,
    m_rec_payload, m_rec_timestamp
  );
endinterface

// File: rtl/astropix_frame_deframer.sv
// astropix_frame_deframer: validates LEN/ID/HDR/payload/TS framing and emits one record per frame
//   clk, resn          : clock, asynchronous active-low reset
//   enable             : 0 freezes the deframer and deasserts tready
//   cfg_layer_reset    : synchronous clear, same effect as resn
//   bus                : byte stream input and record output (slave modport)
//   stat_frame_ok      : 1-cycle pulse per record emitted
//   stat_frame_error   : 1-cycle pulse per malformed frame
//   status_busy        : high whenever not waiting for a LEN byte
module astropix_frame_deframer #(
  parameter int MAX_PAYLOAD = 7,
  parameter bit CHECK_LAYER = 1'b0,
  parameter logic [7:0] EXPECTED_LAYER = 8'h00
) (
  input logic clk,
  input logic resn,
  input logic enable,
  input logic cfg_layer_reset,
  astropix_frame_deframer_if.slave bus,
  output logic stat_frame_ok,
  output logic stat_frame_error,
  output logic status_busy
);
  typedef enum logic [3:0] {LEN, ID, HDR, PAY, TS0, TS1, TS2, TS3, OUT, DROP} state_t;
  state_t state;
  logic [7:0] len, layer, header;
  logic [2:0] remaining, idx;
  logic [8*MAX_PAYLOAD-1:0] payload;
  logic [31:0] timestamp;
  logic take, l;
  logic [7:0] d;
  assign d = bus.s_axis_tdata;
  assign l = bus.s_axis_tlast;
  assign bus.s_axis_tready = enable && state != OUT;
  assign take = bus.s_axis_tvalid && bus.s_axis_tready;
  // payload bytes fill upward from index 0 as remaining counts down
  assign idx = header[2:0] - remaining;
  assign bus.m_rec_valid = state == OUT;
  assign bus.m_rec_layer = layer;
  assign bus.m_rec_header = header;
  assign bus.m_rec_count = header[2:0];
  assign bus.m_rec_payload = payload;
  assign bus.m_rec_timestamp = timestamp;
  assign status_busy = state != LEN;
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state <= LEN;
      {len, layer, header, remaining, payload, timestamp} <= '0;
      {stat_frame_ok, stat_frame_error} <= 2'b00;
    end else if (cfg_layer_reset) begin
      state <= LEN;
      {len, layer, header, remaining, payload, timestamp} <= '0;
      {stat_frame_ok, stat_frame_error} <= 2'b00;
    end else begin
      stat_frame_ok <= 1'b0;
      stat_frame_error <= 1'b0;
      if (state == OUT) begin
        if (enable && bus.m_rec_ready) state <= LEN;
      end else if (take) begin
        case (state)
          LEN: begin
            len <= d;
            if (d < 8'd6 || d > 8'(MAX_PAYLOAD + 6) || l) begin
              stat_frame_error <= 1'b1;
              state <= l ? LEN : DROP;
            end else state <= ID;
          end
          ID: begin
            layer <= d;
            if (l) begin
              stat_frame_error <= 1'b1;
              state <= LEN;
            end else if (CHECK_LAYER && d != EXPECTED_LAYER) begin
              stat_frame_error <= 1'b1;
              state <= DROP;
            end else state <= HDR;
          end
          HDR: begin
            header <= d;
            payload <= '0;
            remaining <= d[2:0];
            if (l) begin
              stat_frame_error <= 1'b1;
              state <= LEN;
            end else if ({5'd0, d[2:0]} + 8'd6 != len) begin
              stat_frame_error <= 1'b1;
              state <= DROP;
            end else state <= d[2:0] != 3'd0 ? PAY : TS0;
          end
          PAY: begin
            payload[8*idx +: 8] <= d;
            remaining <= remaining - 3'd1;
            stat_frame_error <= l;
            state <= l ? LEN : remaining == 3'd1 ? TS0 : PAY;
          end
          TS0: begin
            timestamp[7:0] <= d;
            stat_frame_error <= l;
            state <= l ? LEN : TS1;
          end
          TS1: begin
            timestamp[15:8] <= d;
            stat_frame_error <= l;
            state <= l ? LEN : TS2;
          end
          TS2: begin
            timestamp[23:16] <= d;
            stat_frame_error <= l;
            state <= l ? LEN : TS3;
          end
          TS3: begin
            timestamp[31:24] <= d;
            stat_frame_ok <= l;
            stat_frame_error <= !l;
            state <= l ? OUT : DROP;
          end
          DROP: state <= l ? LEN : DROP;
          default: state <= LEN;
        endcase
      end
    end
  end
endmodule
